// File: rtl/cfg_reg_pkg.sv
// Shared definitions for the configuration register bank: commit FSM states,
// CTRL bit positions and the address map as functions of the segment count.
package cfg_reg_pkg;

    typedef enum logic [1:0] {
        CS_IDLE,
        CS_PENDING,
        CS_APPLY
    } commit_state_t;

    localparam int unsigned CTRL_COMMIT_BIT = 0;
    localparam int unsigned CTRL_ABORT_BIT  = 1;

    function automatic int unsigned linea_base(input int unsigned n);
        return 0;
    endfunction

    function automatic int unsigned linet_base(input int unsigned n);
        return n;
    endfunction

    function automatic int unsigned linenmb_addr(input int unsigned n);
        return 2 * n;
    endfunction

    function automatic int unsigned repeatcycle_addr(input int unsigned n);
        return 2 * n + 1;
    endfunction

    function automatic int unsigned offset_base(input int unsigned n);
        return 2 * n + 2;
    endfunction

    function automatic int unsigned linet_int_base(input int unsigned n);
        return 3 * n + 2;
    endfunction

    // CTRL sits directly after the last parameter word, so it also equals
    // the number of parameter registers.
    function automatic int unsigned ctrl_addr(input int unsigned n);
        return 4 * n + 2;
    endfunction

    function automatic int unsigned status_addr(input int unsigned n);
        return 4 * n + 3;
    endfunction

    function automatic int unsigned addr_span(input int unsigned n);
        return 4 * n + 4;
    endfunction

endpackage

// File: rtl/cfg_commit_fsm.sv
// Commit sequencing: decides when the shadow copy may be applied, keeps the
// commit counter and produces the post-update strobe.
module cfg_commit_fsm
    import cfg_reg_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       commit_i,
    input  logic       abort_i,
    input  logic       gen_idle_i,
    input  logic       gen_boundary_i,
    output logic       apply_o,
    output logic       commit_pending_o,
    output logic       update_strobe_o,
    output logic [7:0] commit_cnt_o
);

    commit_state_t state_q;
    logic          commit_q;
    logic          abort_q;
    logic          idle_q;
    logic          boundary_q;
    logic          pending_q;
    logic          strobe_q;
    logic [7:0]    cnt_q;

    // Requests are registered once ahead of the state logic, so an apply
    // lands two edges after the write or boundary that triggered it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= CS_IDLE;
            commit_q   <= 1'b0;
            abort_q    <= 1'b0;
            idle_q     <= 1'b0;
            boundary_q <= 1'b0;
            pending_q  <= 1'b0;
            strobe_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            commit_q   <= commit_i & ~abort_i;
            abort_q    <= abort_i;
            idle_q     <= gen_idle_i;
            boundary_q <= gen_boundary_i;
            strobe_q   <= 1'b0;
            unique case (state_q)
                CS_IDLE: begin
                    if (commit_q) begin
                        if (idle_q) begin
                            state_q <= CS_APPLY;
                        end else begin
                            state_q   <= CS_PENDING;
                            pending_q <= 1'b1;
                        end
                    end
                end
                CS_PENDING: begin
                    if (abort_q) begin
                        state_q   <= CS_IDLE;
                        pending_q <= 1'b0;
                    end else if (boundary_q || idle_q) begin
                        state_q   <= CS_APPLY;
                        pending_q <= 1'b0;
                    end
                end
                CS_APPLY: begin
                    state_q  <= CS_IDLE;
                    cnt_q    <= cnt_q + 8'd1;
                    strobe_q <= 1'b1;
                end
                default: begin
                    state_q   <= CS_IDLE;
                    pending_q <= 1'b0;
                end
            endcase
        end
    end

    assign apply_o          = (state_q == CS_APPLY);
    assign commit_pending_o = pending_q;
    assign update_strobe_o  = strobe_q;
    assign commit_cnt_o     = cnt_q;

endmodule

// File: rtl/cfg_reg_bank.sv
// Double-buffered configuration register bank: bus writes go to a shadow
// copy, and a commit moves the whole copy to the active outputs at once.
module cfg_reg_bank
    import cfg_reg_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = 8,
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned NUM_LINES = 9
) (
    input  logic                                aclk,
    input  logic                                aresetn,
    input  logic                                s_awvalid,
    input  logic                                s_dwvalid,
    input  logic [ADDR_SIZE-1:0]                s_waddr,
    input  logic [DATA_SIZE-1:0]                s_wdata,
    output logic                                s_wready,
    output logic                                s_bvalid,
    output logic                                s_berr,
    input  logic                                s_arvalid,
    input  logic [ADDR_SIZE-1:0]                s_raddr,
    output logic                                s_arready,
    output logic                                s_rvalid,
    output logic [DATA_SIZE-1:0]                s_rdata,
    output logic                                s_rerr,
    input  logic                                gen_idle,
    input  logic                                gen_boundary,
    output logic [NUM_LINES-1:0][DATA_SIZE-1:0] linea,
    output logic [NUM_LINES-1:0][DATA_SIZE-1:0] linet,
    output logic [NUM_LINES-1:0][DATA_SIZE-1:0] offset,
    output logic [NUM_LINES-1:0][DATA_SIZE-1:0] linet_int,
    output logic [DATA_SIZE-1:0]                linenmb,
    output logic [DATA_SIZE-1:0]                repeatcycle,
    output logic                                update_strobe,
    output logic                                commit_pending
);

    localparam int unsigned NPARAM        = ctrl_addr(NUM_LINES);
    localparam int unsigned LINEA_B       = linea_base(NUM_LINES);
    localparam int unsigned LINET_B       = linet_base(NUM_LINES);
    localparam int unsigned LINENMB_A     = linenmb_addr(NUM_LINES);
    localparam int unsigned REPEATCYCLE_A = repeatcycle_addr(NUM_LINES);
    localparam int unsigned OFFSET_B      = offset_base(NUM_LINES);
    localparam int unsigned LINET_INT_B   = linet_int_base(NUM_LINES);

    localparam logic [ADDR_SIZE-1:0] CTRL_A   = ADDR_SIZE'(ctrl_addr(NUM_LINES));
    localparam logic [ADDR_SIZE-1:0] STATUS_A = ADDR_SIZE'(status_addr(NUM_LINES));

    if (NUM_LINES < 1 || DATA_SIZE < 16 ||
        64'(addr_span(NUM_LINES)) > (64'd1 << ADDR_SIZE)) begin : g_param_check
        $error("cfg_reg_bank: register map does not fit the address/data width");
    end

    logic                 wr_en;
    logic                 wr_param;
    logic                 wr_ctrl;
    logic                 rd_param;
    logic                 rd_status;
    logic                 apply;
    logic [7:0]           commit_cnt;
    logic [DATA_SIZE-1:0] status_word;
    logic [DATA_SIZE-1:0] rd_word_d;

    logic [DATA_SIZE-1:0] shadow_q [NPARAM];
    logic [DATA_SIZE-1:0] shadow_d [NPARAM];
    logic [DATA_SIZE-1:0] active_q [NPARAM];

    logic                 bvalid_q;
    logic                 berr_q;
    logic                 rvalid_q;
    logic                 rerr_q;
    logic [DATA_SIZE-1:0] rdata_q;

    assign wr_en     = s_awvalid & s_dwvalid;
    assign wr_param  = (s_waddr < CTRL_A);
    assign wr_ctrl   = (s_waddr == CTRL_A);
    assign rd_param  = (s_raddr < CTRL_A);
    assign rd_status = (s_raddr == STATUS_A);

    cfg_commit_fsm u_commit_fsm (
        .clk_i            (aclk),
        .rst_ni           (aresetn),
        .commit_i         (wr_en & wr_ctrl & s_wdata[CTRL_COMMIT_BIT]),
        .abort_i          (wr_en & wr_ctrl & s_wdata[CTRL_ABORT_BIT]),
        .gen_idle_i       (gen_idle),
        .gen_boundary_i   (gen_boundary),
        .apply_o          (apply),
        .commit_pending_o (commit_pending),
        .update_strobe_o  (update_strobe),
        .commit_cnt_o     (commit_cnt)
    );

    always_comb begin
        status_word       = '0;
        status_word[15:8] = commit_cnt;
        status_word[0]    = commit_pending;
        shadow_d          = shadow_q;
        rd_word_d         = '0;
        for (int unsigned i = 0; i < NPARAM; i++) begin
            if (wr_en && s_waddr == ADDR_SIZE'(i)) begin
                shadow_d[i] = s_wdata;
            end
            if (s_raddr == ADDR_SIZE'(i)) begin
                rd_word_d = shadow_q[i];
            end
        end
        if (rd_status) begin
            rd_word_d = status_word;
        end
    end

    // Apply copies the pre-edge shadow, so a same-cycle bus write is only
    // seen by the shadow copy.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int unsigned i = 0; i < NPARAM; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            bvalid_q <= 1'b0;
            berr_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rerr_q   <= 1'b0;
            rdata_q  <= '0;
        end else begin
            shadow_q <= shadow_d;
            if (apply) begin
                active_q <= shadow_q;
            end
            bvalid_q <= wr_en;
            berr_q   <= wr_en & ~(wr_param | wr_ctrl);
            rvalid_q <= s_arvalid;
            rerr_q   <= s_arvalid & ~(rd_param | rd_status);
            rdata_q  <= s_arvalid ? rd_word_d : '0;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_LINES; i++) begin
            linea[i]     = active_q[LINEA_B + i];
            linet[i]     = active_q[LINET_B + i];
            offset[i]    = active_q[OFFSET_B + i];
            linet_int[i] = active_q[LINET_INT_B + i];
        end
        linenmb     = active_q[LINENMB_A];
        repeatcycle = active_q[REPEATCYCLE_A];
    end

    assign s_wready  = 1'b1;
    assign s_arready = 1'b1;
    assign s_bvalid  = bvalid_q;
    assign s_berr    = berr_q;
    assign s_rvalid  = rvalid_q;
    assign s_rerr    = rerr_q;
    assign s_rdata   = rdata_q;

endmodule

// File: tb/tb_cfg_reg_bank.sv
// Bench for cfg_reg_bank: vector table, directed commit/abort/reset sequences
// and random traffic, all compared each cycle against a reference model.
module tb_cfg_reg_bank;

    localparam int AW   = 8;
    localparam int DW   = 32;
    localparam int N    = 9;
    localparam int NP   = 4 * N + 2;
    localparam int CTRL = 4 * N + 2;
    localparam int STAT = 4 * N + 3;

    logic                 aclk = 1'b0;
    logic                 aresetn = 1'b0;
    logic                 s_awvalid = 1'b0;
    logic                 s_dwvalid = 1'b0;
    logic [AW-1:0]        s_waddr = '0;
    logic [DW-1:0]        s_wdata = '0;
    logic                 s_arvalid = 1'b0;
    logic [AW-1:0]        s_raddr = '0;
    logic                 gen_idle = 1'b0;
    logic                 gen_boundary = 1'b0;
    logic                 s_wready;
    logic                 s_bvalid;
    logic                 s_berr;
    logic                 s_arready;
    logic                 s_rvalid;
    logic [DW-1:0]        s_rdata;
    logic                 s_rerr;
    logic [N-1:0][DW-1:0] linea;
    logic [N-1:0][DW-1:0] linet;
    logic [N-1:0][DW-1:0] offset;
    logic [N-1:0][DW-1:0] linet_int;
    logic [DW-1:0]        linenmb;
    logic [DW-1:0]        repeatcycle;
    logic                 update_strobe;
    logic                 commit_pending;

    cfg_reg_bank #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .NUM_LINES(N)) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .s_awvalid      (s_awvalid),
        .s_dwvalid      (s_dwvalid),
        .s_waddr        (s_waddr),
        .s_wdata        (s_wdata),
        .s_wready       (s_wready),
        .s_bvalid       (s_bvalid),
        .s_berr         (s_berr),
        .s_arvalid      (s_arvalid),
        .s_raddr        (s_raddr),
        .s_arready      (s_arready),
        .s_rvalid       (s_rvalid),
        .s_rdata        (s_rdata),
        .s_rerr         (s_rerr),
        .gen_idle       (gen_idle),
        .gen_boundary   (gen_boundary),
        .linea          (linea),
        .linet          (linet),
        .offset         (offset),
        .linet_int      (linet_int),
        .linenmb        (linenmb),
        .repeatcycle    (repeatcycle),
        .update_strobe  (update_strobe),
        .commit_pending (commit_pending)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int failures = 0;

    // Reference model: shadow/active word arrays indexed by bus address,
    // plus commit bookkeeping. Requests act one edge after they are sampled.
    logic [DW-1:0] m_sh [NP];
    logic [DW-1:0] m_act [NP];
    bit            m_pend, m_apply, m_strobe;
    int            m_cnt;
    bit            p_cm, p_ab, p_gb, p_gi;
    bit            m_bvalid, m_berr, m_rvalid, m_rerr;
    logic [DW-1:0] m_rdata;

    typedef struct {
        bit            awv;
        int            waddr;
        logic [DW-1:0] wdata;
        bit            arv;
        int            raddr;
        bit            e_berr;
        logic [DW-1:0] e_rdata;
        bit            e_rerr;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] get_act(input int a);
        if (a < N)          return linea[a];
        if (a < 2 * N)      return linet[a - N];
        if (a == 2 * N)     return linenmb;
        if (a == 2 * N + 1) return repeatcycle;
        if (a < 3 * N + 2)  return offset[a - 2 * N - 2];
        return linet_int[a - 3 * N - 2];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NP; i++) begin
            m_sh[i]  = '0;
            m_act[i] = '0;
        end
        m_pend = 0; m_apply = 0; m_strobe = 0; m_cnt = 0;
        p_cm = 0; p_ab = 0; p_gb = 0; p_gi = 0;
        m_bvalid = 0; m_berr = 0; m_rvalid = 0; m_rerr = 0; m_rdata = '0;
    endtask

    task automatic model_edge();
        int wa, ra;
        bit wr;
        if (!aresetn) begin
            model_reset();
            return;
        end
        wa = int'(s_waddr);
        ra = int'(s_raddr);
        wr = s_awvalid && s_dwvalid;
        m_bvalid = wr;
        m_berr   = wr && (wa > CTRL);
        m_rvalid = s_arvalid;
        m_rerr   = 0;
        m_rdata  = '0;
        if (s_arvalid) begin
            if (ra < NP)          m_rdata = m_sh[ra];
            else if (ra == STAT)  m_rdata = (DW'(m_cnt % 256) << 8) | DW'(m_pend);
            else                  m_rerr = 1;
        end
        m_strobe = 0;
        if (m_apply) begin
            for (int i = 0; i < NP; i++) m_act[i] = m_sh[i];
            m_cnt++;
            m_strobe = 1;
            m_apply  = 0;
        end else if (m_pend) begin
            if (p_ab) m_pend = 0;
            else if (p_gb || p_gi) begin
                m_pend  = 0;
                m_apply = 1;
            end
        end else if (p_cm && !p_ab) begin
            if (p_gi) m_apply = 1;
            else      m_pend  = 1;
        end
        p_cm = wr && (wa == CTRL) && s_wdata[0];
        p_ab = wr && (wa == CTRL) && s_wdata[1];
        p_gb = gen_boundary;
        p_gi = gen_idle;
        if (wr && wa < NP) m_sh[wa] = s_wdata;
    endtask

    task automatic compare_all();
        chk("wready", 32'(s_wready), 32'd1);
        chk("arready", 32'(s_arready), 32'd1);
        chk("bvalid", 32'(s_bvalid), 32'(m_bvalid));
        chk("berr", 32'(s_berr), 32'(m_berr));
        chk("rvalid", 32'(s_rvalid), 32'(m_rvalid));
        chk("rdata", s_rdata, m_rdata);
        chk("rerr", 32'(s_rerr), 32'(m_rerr));
        chk("commit_pending", 32'(commit_pending), 32'(m_pend));
        chk("update_strobe", 32'(update_strobe), 32'(m_strobe));
        for (int a = 0; a < NP; a++) chk($sformatf("active[%0d]", a), get_act(a), m_act[a]);
    endtask

    task automatic cyc();
        @(posedge aclk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic bus_idle();
        s_awvalid = 0; s_dwvalid = 0; s_arvalid = 0; gen_boundary = 0;
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d);
        s_awvalid = 1; s_dwvalid = 1; s_waddr = AW'(a); s_wdata = d;
    endtask

    task automatic rd(input int a);
        s_arvalid = 1; s_raddr = AW'(a);
    endtask

    task automatic add(input bit awv, input int wa, input logic [DW-1:0] wd, input bit arv,
                       input int ra, input bit eb, input logic [DW-1:0] erd, input bit ere);
        vec_t v;
        v.awv = awv; v.waddr = wa; v.wdata = wd; v.arv = arv; v.raddr = ra;
        v.e_berr = eb; v.e_rdata = erd; v.e_rerr = ere;
        tbl.push_back(v);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit gb_prev;
        model_reset();
        repeat (3) @(posedge aclk);
        #1;
        compare_all();
        aresetn = 1;

        add(0, 0,   32'h0,    1, STAT, 0, 32'h0,    0);
        add(1, 10,  32'h1234, 0, 0,    0, 32'h0,    0);
        add(0, 0,   32'h0,    1, 10,   0, 32'h1234, 0);
        add(1, STAT,32'hFFFF, 1, 10,   1, 32'h1234, 0);
        add(1, 200, 32'hDEAD, 1, 200,  1, 32'h0,    1);
        add(0, 0,   32'h0,    1, CTRL, 0, 32'h0,    1);
        add(1, 0,   32'hA5,   1, 0,    0, 32'h0,    0);
        add(0, 0,   32'h0,    1, 0,    0, 32'hA5,   0);
        add(1, 37,  32'h77,   1, 36,   0, 32'h0,    0);
        add(0, 0,   32'h0,    1, 37,   0, 32'h77,   0);
        add(1, 18,  32'h3,    1, STAT, 0, 32'h0,    0);
        add(1, CTRL,32'h0,    1, 18,   0, 32'h3,    0);
        foreach (tbl[i]) begin
            bus_idle();
            if (tbl[i].awv) wr(tbl[i].waddr, tbl[i].wdata);
            if (tbl[i].arv) rd(tbl[i].raddr);
            cyc();
            chk($sformatf("vec%0d_bvalid", i), 32'(s_bvalid), 32'(tbl[i].awv));
            chk($sformatf("vec%0d_berr", i), 32'(s_berr), 32'(tbl[i].e_berr));
            chk($sformatf("vec%0d_rvalid", i), 32'(s_rvalid), 32'(tbl[i].arv));
            chk($sformatf("vec%0d_rdata", i), s_rdata, tbl[i].e_rdata);
            chk($sformatf("vec%0d_rerr", i), 32'(s_rerr), 32'(tbl[i].e_rerr));
        end
        bus_idle();

        // Commit with the sequencer idle: outputs change two edges later.
        gen_idle = 1; wr(CTRL, 32'h1); cyc();
        bus_idle(); gen_idle = 0;
        chk("idle_k_linet1", linet[1], 32'h0);
        cyc();
        chk("idle_k1_linet1", linet[1], 32'h0);
        chk("idle_k1_strobe", 32'(update_strobe), 32'd0);
        cyc();
        chk("idle_k2_linet1", linet[1], 32'h1234);
        chk("idle_k2_strobe", 32'(update_strobe), 32'd1);
        chk("idle_k2_linea0", linea[0], 32'hA5);
        cyc();
        chk("idle_k3_strobe", 32'(update_strobe), 32'd0);
        rd(STAT); cyc(); bus_idle();
        chk("status_after_one", s_rdata, 32'h100);

        // Commit held pending until a boundary pulse.
        wr(10, 32'h5678); cyc(); bus_idle();
        wr(CTRL, 32'h1); cyc(); bus_idle();
        cyc();
        chk("pend_set", 32'(commit_pending), 32'd1);
        repeat (20) begin
            cyc();
            chk("pend_hold", 32'(commit_pending), 32'd1);
            chk("pend_hold_linet1", linet[1], 32'h1234);
        end
        gen_boundary = 1; cyc(); gen_boundary = 0;
        chk("bnd_b_linet1", linet[1], 32'h1234);
        cyc();
        chk("bnd_b1_linet1", linet[1], 32'h1234);
        chk("bnd_b1_pend", 32'(commit_pending), 32'd0);
        cyc();
        chk("bnd_b2_linet1", linet[1], 32'h5678);
        chk("bnd_b2_strobe", 32'(update_strobe), 32'd1);

        // Abort while pending, then commit+abort in one word.
        wr(10, 32'h9ABC); cyc(); bus_idle();
        wr(CTRL, 32'h1); cyc(); bus_idle();
        cyc();
        chk("abort_pend_set", 32'(commit_pending), 32'd1);
        wr(CTRL, 32'h2); cyc(); bus_idle();
        cyc();
        chk("abort_pend_clr", 32'(commit_pending), 32'd0);
        gen_boundary = 1; cyc(); gen_boundary = 0;
        repeat (4) begin
            cyc();
            chk("abort_no_strobe", 32'(update_strobe), 32'd0);
            chk("abort_linet1", linet[1], 32'h5678);
        end
        wr(CTRL, 32'h3); cyc(); bus_idle();
        repeat (3) begin
            cyc();
            chk("both_bits_pend", 32'(commit_pending), 32'd0);
        end

        // Random traffic against the model.
        gb_prev = 0;
        for (int c = 0; c < 2000; c++) begin
            int r;
            bus_idle();
            if ($urandom_range(0, 2) == 0) begin
                s_awvalid = 1;
                s_dwvalid = ($urandom_range(0, 3) != 0);
                r = int'($urandom_range(0, 15));
                if (r == 0) begin
                    s_waddr = AW'($urandom_range(40, 255));
                    s_wdata = $urandom;
                end else if (r < 3) begin
                    s_waddr = AW'(CTRL);
                    s_wdata = DW'($urandom_range(0, 3));
                end else begin
                    s_waddr = AW'($urandom_range(0, 39));
                    s_wdata = $urandom;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                s_dwvalid = 1;
                s_waddr = AW'($urandom_range(0, 37));
                s_wdata = $urandom;
            end
            if ($urandom_range(0, 1) == 0) begin
                rd(($urandom_range(0, 15) == 0) ? int'($urandom_range(40, 255))
                                                : int'($urandom_range(0, 39)));
            end
            gen_idle = ($urandom_range(0, 3) == 0);
            gen_boundary = !gb_prev && ($urandom_range(0, 9) == 0);
            gb_prev = gen_boundary;
            cyc();
        end
        bus_idle(); gen_idle = 0;

        // Counter wrap after 256 commits.
        aresetn = 0; model_reset(); #1; compare_all();
        cyc(); aresetn = 1;
        gen_idle = 1;
        for (int k = 0; k < 256; k++) begin
            wr(CTRL, 32'h1); cyc(); bus_idle();
            repeat (3) cyc();
        end
        rd(STAT); cyc(); bus_idle();
        chk("status_wrap", s_rdata, 32'h0);
        wr(CTRL, 32'h1); cyc(); bus_idle();
        repeat (3) cyc();
        rd(STAT); cyc(); bus_idle();
        chk("status_after_wrap", s_rdata, 32'h100);
        gen_idle = 0;

        // Reset while a commit is pending discards it.
        wr(5, 32'hCAFE); cyc(); bus_idle();
        wr(CTRL, 32'h1); cyc(); bus_idle();
        cyc();
        chk("rst_pend_set", 32'(commit_pending), 32'd1);
        #2;
        aresetn = 0; model_reset();
        #1;
        compare_all();
        chk("rst_pend_clr", 32'(commit_pending), 32'd0);
        chk("rst_linet1", linet[1], 32'h0);
        cyc(); cyc();
        aresetn = 1;
        wr(5, 32'hBEEF); cyc(); bus_idle();
        gen_boundary = 1; cyc(); gen_boundary = 0;
        repeat (4) begin
            cyc();
            chk("rst_no_strobe", 32'(update_strobe), 32'd0);
            chk("rst_linea5", linea[5], 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cfg_reg_bank.md
# cfg_reg_bank

Parametrised, double-buffered configuration register bank for the signal generator. A bus master writes per-segment waveform parameters (amplitude, duration, offset, fractional duration) and global parameters into a shadow copy. An explicit commit transfers the shadow copy to the active outputs only at a generator-safe boundary, so the sequencer never sees a half-updated segment table. It adds readback, write/read error responses and a status word, and sits between the config bus and the waveform sequencer.

## Interface
- `ADDR_SIZE`, 8, word address width
- `DATA_SIZE`, 32, register width
- `NUM_LINES`, 9, number of waveform segments (≥1)
- `aclk`  in  1  clock
- `aresetn`  in  1  reset; asynchronous, active-low
- `s_awvalid`, `s_dwvalid`  in  1  write address / data valid
- `s_waddr`  in  ADDR_SIZE  write word address
- `s_wdata`  in  DATA_SIZE  write data
- `s_wready`  out  1  write accept; constant 1 out of reset
- `s_bvalid`  out  1  write response pulse
- `s_berr`  out  1  write error, qualified by `s_bvalid`
- `s_arvalid`  in  1  read request
- `s_raddr`  in  ADDR_SIZE  read word address
- `s_arready`  out  1  constant 1 out of reset
- `s_rvalid`  out  1  read data pulse
- `s_rdata`  out  DATA_SIZE  read data
- `s_rerr`  out  1  read error
- `gen_idle`  in  1  sequencer stopped; commit may apply at once
- `gen_boundary`  in  1  single-cycle pulse at end of a repeat cycle
- `linea`, `linet`, `offset`, `linet_int`  out  NUM_LINES×DATA_SIZE  active per-segment arrays
- `linenmb`, `repeatcycle`  out  DATA_SIZE  active globals
- `update_strobe`  out  1  one-cycle pulse in the cycle after active registers change
- `commit_pending`  out  1  a commit is waiting for a boundary

## Operation
- Address map, with N=NUM_LINES:
  - linea: 0..N-1
  - linet: N..2N-1
  - linenmb: 2N
  - repeatcycle: 2N+1
  - offset: 2N+2..3N+1
  - linet_int: 3N+2..4N+1
  - CTRL: 4N+2 (write-only)
  - STATUS: 4N+3 (read-only)
  - With N=9 the parameter layout is 0..37, CTRL=38, STATUS=39.
- A write is accepted when `s_awvalid & s_dwvalid`.
  - Parameter address: updates the shadow register.
  - CTRL: bit0 = commit, bit1 = abort.
  - STATUS or unmapped: no state change, `s_berr`=1.
- Reads return the shadow value for parameter addresses. STATUS reads as:
  - bit0 = `commit_pending`
  - bits[15:8] = commit counter (mod 256)
  - other bits 0
- CTRL or unmapped reads return 0 with `s_rerr`=1.
- Commit FSM has three states: IDLE, PENDING, APPLY.
  - IDLE, commit written, `gen_idle`=1 → APPLY.
  - IDLE, commit written, `gen_idle`=0 → PENDING.
  - PENDING → APPLY on `gen_boundary` or `gen_idle`.
  - PENDING, abort written → IDLE; active registers untouched.
  - APPLY: copy all shadow registers to active, increment counter → IDLE.
  - Commit written while in PENDING or APPLY: ignored, `s_berr`=0.
  - Commit and abort written in the same word: abort wins.
- A parameter write in the same cycle as APPLY lands in shadow only. Active registers take the shadow contents as registered before that edge.
- Reset values:
  - All shadow and active registers, counter and FSM (IDLE) are 0.
  - `s_bvalid`, `s_rvalid`, `update_strobe`, `commit_pending` = 0.
  - `s_wready`, `s_arready` = 1.
- Reset mid-PENDING discards the commit. The counter wraps 255→0.

## Timing
- Write: `s_bvalid`/`s_berr` are asserted exactly one cycle after acceptance. The shadow value is readable on the next cycle's read request.
- Read: `s_rvalid`/`s_rdata`/`s_rerr` one cycle after `s_arvalid`. No backpressure. `s_rdata` is 0 when `s_rvalid`=0.
- A read and a write to the same address in the same cycle: the read returns the old value.
- Commit with `gen_idle`=1:
  - Write accepted at edge k, APPLY state at k+1.
  - Active outputs change at k+2.
  - `update_strobe` high during the cycle after k+2.
- Commit with a boundary: `gen_boundary` sampled high at edge b → APPLY at b+1 → outputs change at b+2.
- `commit_pending` is registered and high exactly while the FSM is in PENDING.

## Structure
- Package `cfg_reg_pkg` holds:
  - FSM enum `commit_state_t`
  - CTRL bit indices
  - address-base functions of N (`linea_base`, `linet_base`, … `status_addr`)
- Elaboration assertion: 4N+4 ≤ 2**ADDR_SIZE.
- One sub-module `cfg_commit_fsm` (FSM + counter + strobe); the top holds the storage, decode and read mux.

## Test plan
- Reset, then read STATUS → `s_rdata`=0, `s_rerr`=0. All active outputs 0; `s_wready`=1.
- N=9: write 0x1234 to addr 10, read addr 10 → 0x1234. Active `linet[1]` stays 0 until commit with `gen_idle`=1 → `linet[1]`=0x1234 at k+2, `update_strobe` one pulse, STATUS[15:8]=1.
- `gen_idle`=0: commit → `commit_pending`=1 → hold 20 cycles, outputs unchanged. Pulse `gen_boundary` → outputs update two edges later, pending clears.
- Commit pending, then write CTRL=0x2 → FSM IDLE, active unchanged, next `gen_boundary` has no effect.
- Write addr 39 and addr 200 → `s_berr`=1, no state change. Read addr 38 → `s_rerr`=1, data 0.
- 256 commits → counter reads 0. Assert `aresetn` low while PENDING → all outputs 0, then a `gen_boundary` after release causes no update.
